seq_gen_scheduler: RTL and testbench
====================================

SEQ_GEN_SCHEDULER -- requirements
Module: seq_gen_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing one sequence generator.
REQ-002 The block SHALL have parameter SEQ_LEN, default 8, meaning the number of serial bits captured per service.
REQ-003 The block SHALL have parameter START_LAT, default 1 (legal 1..15), meaning the cycles from the gen_start cycle to the cycle the first data bit is sampled.
REQ-004 clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  N_REQ  per-requester service request, level.
REQ-007 gnt  out  N_REQ  one-hot grant, held for the whole service.
REQ-008 gen_start  out  1  start pulse to the sequence generator.
REQ-009 gen_data_out  in  1  serial output of the sequence generator.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rsp_data  out  SEQ_LEN  captured sequence, first bit captured in the MSB.
REQ-012 rsp_id  out  clog2(N_REQ)  index of the serviced requester.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, START, WAIT, CAPTURE and DONE.
REQ-015 IDLE with req==0 SHALL remain in IDLE.
REQ-016 IDLE with req!=0 SHALL pick a winner round-robin, searching from last_gnt+1 upward with wrap, latch gnt and rsp_id, and go to START.
REQ-017 START SHALL last exactly one cycle with gen_start=1, then go to WAIT if START_LAT>1, else CAPTURE.
REQ-018 gen_start SHALL be 0 in every state other than START.
REQ-019 WAIT SHALL last START_LAT-1 cycles.
REQ-020 CAPTURE SHALL last SEQ_LEN cycles and shift in gen_data_out each cycle (rsp_data <= {rsp_data[SEQ_LEN-2:0], gen_data_out}).
REQ-021 The CAPTURE bit counter SHALL terminate at SEQ_LEN-1 without wrap.
REQ-022 DONE SHALL assert done for one cycle with rsp_data and rsp_id valid, update last_gnt to the winner, and go to IDLE.
REQ-023 gnt SHALL be asserted from START through DONE inclusive and be 0 in IDLE.
REQ-024 rsp_data and rsp_id SHALL hold their values until the next DONE.
REQ-025 Deassertion of the granted req during service SHALL be ignored; the service SHALL complete and done SHALL still pulse.
REQ-026 Requests arriving mid-service SHALL be held pending and evaluated only in IDLE.
REQ-027 A requester still requesting after its own DONE SHALL have lowest priority in the next arbitration.
REQ-028 Minimum service period SHALL be START_LAT+SEQ_LEN+2 cycles, IDLE to IDLE.
REQ-029 With req all ones, grants SHALL rotate 0,1,2,3,0,...

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, gnt=0, gen_start=0, done=0, busy=0, rsp_data=0, rsp_id=0, bit counter=0, last_gnt=N_REQ-1.
REQ-031 Reset mid-service SHALL abandon the service without a done pulse; after release the first grant SHALL favour requester 0.

Structure
REQ-032 A shared package seq_sched_pkg SHALL hold the state enum type and the default constants for N_REQ, SEQ_LEN and START_LAT.
REQ-033 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req and last_gnt, output one-hot winner), purely combinational.

Verification
The bench SHALL use SEQ_LEN=8, START_LAT=1 and a generator model that emits 8'hA5 MSB-first starting the cycle after gen_start.
REQ-034 req=4'b0100 from reset -> gnt=4'b0100, one gen_start pulse, done after 11 cycles, rsp_data=8'hA5, rsp_id=2.
REQ-035 req=4'b1111 held -> grant order 0,1,2,3,0, with exactly one gen_start per service and busy low for exactly one cycle between services.
REQ-036 req[1] dropped during CAPTURE -> service completes, done pulses, rsp_id=1.
REQ-037 rst_n low during CAPTURE -> gnt=0 and busy=0 asynchronously, no done; after release req=4'b1010 -> grant to 1.
REQ-038 START_LAT=3 with a model delayed accordingly -> 2 WAIT cycles, rsp_data=8'hA5.
REQ-039 req[3] raised during requester 0's service -> requester 3 granted on the first IDLE after DONE.

Source files
------------

// File: rtl/seq_sched_pkg.sv
// Shared definitions for the sequence-generator scheduler.
// Holds the scheduler state type, the default parameter values and a
// helper that gives the width of an index into n items (at least 1 bit).
package seq_sched_pkg;

   localparam int unsigned DefNReq     = 4;
   localparam int unsigned DefSeqLen   = 8;
   localparam int unsigned DefStartLat = 1;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StWait,
      StCapture,
      StDone
   } sched_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req      - request vector, one bit per requester
//   last_gnt - index of the most recently serviced requester
//   winner   - one-hot winner, searched from last_gnt+1 upward with wrap;
//              all zero when req is all zero
module rr_arbiter
   import seq_sched_pkg::*;
#(
   parameter int unsigned N_REQ = DefNReq,
   localparam int unsigned IdW  = idx_width(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IdW-1:0]   last_gnt,
   output logic [N_REQ-1:0] winner
);

   logic found;

   // First pass covers indices above last_gnt, second pass wraps to the rest,
   // so the previous winner is always considered last.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i > 32'(last_gnt))) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (i <= 32'(last_gnt))) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seq_gen_scheduler.sv
// Shares one serial sequence generator between N_REQ requesters.
// A round-robin winner is granted, the generator is started, SEQ_LEN serial
// bits are captured MSB-first and returned with the winner's index.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   req           - per-requester level request
//   gnt           - one-hot grant, held from START through DONE
//   gen_start     - one-cycle start pulse to the generator
//   gen_data_out  - serial data from the generator
//   done          - one-cycle completion pulse
//   rsp_data      - captured sequence, held until the next done
//   rsp_id        - serviced requester index, held until the next done
//   busy          - high whenever not idle
module seq_gen_scheduler
   import seq_sched_pkg::*;
#(
   parameter int unsigned N_REQ     = DefNReq,
   parameter int unsigned SEQ_LEN   = DefSeqLen,  // must be >= 2
   parameter int unsigned START_LAT = DefStartLat // legal 1..15
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_REQ-1:0]            req,
   output logic [N_REQ-1:0]            gnt,
   output logic                        gen_start,
   input  logic                        gen_data_out,
   output logic                        done,
   output logic [SEQ_LEN-1:0]          rsp_data,
   output logic [idx_width(N_REQ)-1:0] rsp_id,
   output logic                        busy
);

   localparam int unsigned IdW  = idx_width(N_REQ);
   localparam int unsigned BitW = idx_width(SEQ_LEN);
   localparam logic [BitW-1:0] LastBit  = BitW'(SEQ_LEN - 1);
   // Only reached when START_LAT > 1; WAIT counts 0..START_LAT-2.
   localparam logic [3:0]      LastWait = 4'(START_LAT - 2);

   sched_state_e       state_q, state_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [IdW-1:0]     cur_id_q, cur_id_d;
   logic [IdW-1:0]     last_gnt_q, last_gnt_d;
   logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [3:0]         wait_cnt_q, wait_cnt_d;
   logic [SEQ_LEN-2:0] shift_q, shift_d;
   logic [SEQ_LEN-1:0] shift_full;
   logic [SEQ_LEN-1:0] rsp_data_q, rsp_data_d;
   logic [IdW-1:0]     rsp_id_q, rsp_id_d;
   logic [N_REQ-1:0]   win_oh;
   logic [IdW-1:0]     win_id;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req      (req),
      .last_gnt (last_gnt_q),
      .winner   (win_oh)
   );

   always_comb begin
      win_id = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (win_oh[i]) win_id = IdW'(i);
      end
   end

   assign shift_full = {shift_q, gen_data_out};

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      cur_id_d   = cur_id_q;
      last_gnt_d = last_gnt_q;
      bit_cnt_d  = bit_cnt_q;
      wait_cnt_d = wait_cnt_q;
      shift_d    = shift_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      case (state_q)
         StIdle: begin
            if (|req) begin
               gnt_d    = win_oh;
               cur_id_d = win_id;
               state_d  = StStart;
            end
         end
         StStart: begin
            bit_cnt_d  = '0;
            wait_cnt_d = '0;
            state_d    = (START_LAT > 1) ? StWait : StCapture;
         end
         StWait: begin
            if (wait_cnt_q == LastWait) state_d = StCapture;
            else                        wait_cnt_d = wait_cnt_q + 4'd1;
         end
         StCapture: begin
            shift_d = shift_full[SEQ_LEN-2:0];
            if (bit_cnt_q == LastBit) begin
               // Results are published only on entry to DONE so the outputs
               // keep the previous response for the whole of this service.
               rsp_data_d = shift_full;
               rsp_id_d   = cur_id_q;
               state_d    = StDone;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         StDone: begin
            last_gnt_d = cur_id_q;
            gnt_d      = '0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         gnt_q      <= '0;
         cur_id_q   <= '0;
         last_gnt_q <= IdW'(N_REQ - 1);
         bit_cnt_q  <= '0;
         wait_cnt_q <= '0;
         shift_q    <= '0;
         rsp_data_q <= '0;
         rsp_id_q   <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         cur_id_q   <= cur_id_d;
         last_gnt_q <= last_gnt_d;
         bit_cnt_q  <= bit_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         shift_q    <= shift_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign gen_start = (state_q == StStart);
   assign done      = (state_q == StDone);
   assign busy      = (state_q != StIdle);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_seq_gen_scheduler.sv
// Bench for seq_gen_scheduler: two instances (START_LAT 1 and 3) share the
// request stimulus. Each has a cycle-level reference model, a generator model
// and a scoreboard monitor that pops expected responses on done.
module tb_seq_gen_scheduler;

   localparam int NEnv = 2;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   bit         pat_random = 1'b0;
   bit         end_chk    = 1'b0;
   int         cyc      = 0;
   int         n_checks = 0;
   int         n_err    = 0;

   logic [3:0] gnt_w  [NEnv];
   logic       gs_w   [NEnv];
   logic       done_w [NEnv];
   logic       busy_w [NEnv];
   logic [7:0] data_w [NEnv];
   logic [1:0] id_w   [NEnv];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Round robin: first requester after the previous winner, wrapping.
   function automatic int rr_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= 4; k++) begin
         int i;
         i = (last + k) % 4;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   for (genvar g = 0; g < NEnv; g++) begin : g_env
      localparam int Lat    = (g == 0) ? 1 : 3;
      localparam int Period = Lat + 8 + 2;

      logic       gen_data = 1'b0;
      int         phase    = 0;
      int         m_last   = 3;
      int         m_cur    = 0;
      int         exp_id_q[$];
      logic [7:0] exp_data_q[$];
      bit         g_active = 1'b0;
      int         g_start  = 0;
      int         g_idx    = 0;
      logic [7:0] g_byte   = 8'h00;
      int         last_id  = 0;
      logic [7:0] last_data = 8'h00;

      seq_gen_scheduler #(
         .N_REQ     (4),
         .SEQ_LEN   (8),
         .START_LAT (Lat)
      ) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .req          (req),
         .gnt          (gnt_w[g]),
         .gen_start    (gs_w[g]),
         .gen_data_out (gen_data),
         .done         (done_w[g]),
         .rsp_data     (data_w[g]),
         .rsp_id       (id_w[g]),
         .busy         (busy_w[g])
      );

      // Reference model: phase 0 is idle, 1 is the start cycle, Period-1 is done.
      always @(negedge clk) begin
         if (!rst_n) begin
            phase  = 0;
            m_last = 3;
            exp_id_q.delete();
            chk($sformatf("env%0d rst_busy", g), 32'(busy_w[g]), 32'd0);
            chk($sformatf("env%0d rst_gnt", g), 32'(gnt_w[g]), 32'd0);
            chk($sformatf("env%0d rst_gen_start", g), 32'(gs_w[g]), 32'd0);
            chk($sformatf("env%0d rst_done", g), 32'(done_w[g]), 32'd0);
         end else begin
            chk($sformatf("env%0d busy", g), 32'(busy_w[g]), 32'(phase != 0));
            chk($sformatf("env%0d gen_start", g), 32'(gs_w[g]), 32'(phase == 1));
            chk($sformatf("env%0d done", g), 32'(done_w[g]), 32'(phase == Period - 1));
            chk($sformatf("env%0d gnt", g), 32'(gnt_w[g]),
                (phase != 0) ? (32'd1 << m_cur) : 32'd0);
            if (phase == 0) begin
               if (req != 4'b0000) begin
                  m_cur = rr_pick(req, m_last);
                  exp_id_q.push_back(m_cur);
                  phase = 1;
               end
            end else if (phase == Period - 1) begin
               m_last = m_cur;
               phase  = 0;
            end else begin
               phase++;
            end
         end
      end

      // Generator model: bit 7 of the pattern is presented Lat cycles after
      // the start cycle, one bit per cycle, junk otherwise.
      always @(negedge clk) begin
         if (!rst_n) begin
            g_active = 1'b0;
            exp_data_q.delete();
         end else if (gs_w[g]) begin
            g_start  = cyc;
            g_byte   = pat_random ? 8'($urandom) : 8'hA5;
            g_active = 1'b1;
            exp_data_q.push_back(g_byte);
         end
         g_idx = cyc - g_start - Lat;
         if (g_active && g_idx >= 0 && g_idx < 8) gen_data = g_byte[7 - g_idx];
         else                                     gen_data = 1'($urandom);
      end

      // Scoreboard monitor.
      always @(negedge clk) begin
         if (!rst_n) begin
            last_id   = 0;
            last_data = 8'h00;
            chk($sformatf("env%0d rst_rsp_id", g), 32'(id_w[g]), 32'd0);
            chk($sformatf("env%0d rst_rsp_data", g), 32'(data_w[g]), 32'd0);
         end else if (done_w[g]) begin
            chk($sformatf("env%0d done_expected", g),
                32'(exp_id_q.size() > 0 && exp_data_q.size() > 0), 32'd1);
            if (exp_id_q.size() > 0) last_id = exp_id_q.pop_front();
            if (exp_data_q.size() > 0) last_data = exp_data_q.pop_front();
            chk($sformatf("env%0d rsp_id", g), 32'(id_w[g]), 32'(last_id));
            chk($sformatf("env%0d rsp_data", g), 32'(data_w[g]), 32'(last_data));
         end else begin
            chk($sformatf("env%0d rsp_id_hold", g), 32'(id_w[g]), 32'(last_id));
            chk($sformatf("env%0d rsp_data_hold", g), 32'(data_w[g]), 32'(last_data));
         end
      end

      initial begin
         wait (end_chk);
         chk($sformatf("env%0d pending_services", g), 32'(exp_id_q.size()), 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      req = 4'b0000;
      idle(3);
      rst_n = 1'b1;
      idle(2);

      // Single request from reset.
      req = 4'b0100;
      idle(2);
      req = 4'b0000;
      idle(20);

      // All requesting: rotation from requester 0.
      do_reset();
      req = 4'b1111;
      idle(70);
      req = 4'b0000;
      idle(20);

      // Granted request dropped mid-capture.
      do_reset();
      req = 4'b0010;
      idle(6);
      req = 4'b0000;
      idle(20);

      // Asynchronous reset mid-capture.
      do_reset();
      req = 4'b0100;
      idle(6);
      #2 rst_n = 1'b0;
      #1;
      for (int e = 0; e < NEnv; e++) begin
         chk($sformatf("env%0d async_rst_gnt", e), 32'(gnt_w[e]), 32'd0);
         chk($sformatf("env%0d async_rst_busy", e), 32'(busy_w[e]), 32'd0);
         chk($sformatf("env%0d async_rst_done", e), 32'(done_w[e]), 32'd0);
      end
      req = 4'b1010;
      idle(2);
      rst_n = 1'b1;
      idle(15);
      req = 4'b0000;
      idle(20);

      // Request 3 arrives during requester 0's service.
      do_reset();
      req = 4'b0001;
      idle(3);
      req = 4'b1001;
      idle(25);
      req = 4'b0000;
      idle(30);

      // Randomized traffic with random generator patterns and rare resets.
      pat_random = 1'b1;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 249) == 0) begin
            #2 rst_n = 1'b0;
            idle(2);
            rst_n = 1'b1;
         end
         idle(1);
      end

      req = 4'b0000;
      idle(40);
      end_chk = 1'b1;
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
